// File: rtl/stream_checker.sv
// Self-synchronising checker for the sequential / LFSR generator stream: acquires lock, then counts words and errors.
// Optional sticky error flag enabled by defining STREAM_CHECKER_STICKY_EN.
module stream_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             mode,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_seen
);

    // data_valid qualifies data_in for one cycle; there is no back-pressure, every valid word is consumed.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [7:0]       pred, pred_nx;
    logic             has_prev, has_prev_nx;
    logic [3:0]       run, run_nx;
    logic [3:0]       run_inc;
    logic             last_mode, last_mode_nx;
    logic             err_nx;
    logic [CNT_W-1:0] wc_nx, ec_nx;
    logic             zero_lfsr;

    function automatic logic [7:0] next_word(input logic [7:0] d, input logic lfsr);
        if (lfsr)
            return {d[6:3], d[2] ^ d[7], d[1], d[0], d[7]};
        else
            return d + 8'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign run_inc   = run + 4'd1;
    // All-zero is the LFSR lock-up word: never a valid seed, never a match.
    assign zero_lfsr = mode && (data_in == 8'h00);

    always_comb begin
        state_nx     = state;
        pred_nx      = pred;
        has_prev_nx  = has_prev;
        run_nx       = run;
        last_mode_nx = last_mode;
        err_nx       = 1'b0;
        wc_nx        = word_count;
        ec_nx        = err_count;
        if (data_valid) begin
            last_mode_nx = mode;
            if (has_prev && (mode != last_mode)) begin
                state_nx    = SEARCH;
                run_nx      = 4'd0;
                pred_nx     = next_word(data_in, mode);
                has_prev_nx = !zero_lfsr;
            end else if (state == SEARCH) begin
                if (zero_lfsr) begin
                    has_prev_nx = 1'b0;
                    run_nx      = 4'd0;
                end else begin
                    pred_nx     = next_word(data_in, mode);
                    has_prev_nx = 1'b1;
                    if (has_prev) begin
                        if (data_in == pred) begin
                            if (run_inc == 4'(LOCK_CNT)) begin
                                state_nx = LOCKED;
                                run_nx   = 4'd0;
                            end else begin
                                run_nx = run_inc;
                            end
                        end else begin
                            run_nx = 4'd0;
                        end
                    end
                end
            end else begin
                // Free-running prediction: a single bad word does not derail the following ones.
                pred_nx = next_word(pred, mode);
                wc_nx   = sat_inc(word_count);
                if ((data_in != pred) || zero_lfsr) begin
                    err_nx = 1'b1;
                    ec_nx  = sat_inc(err_count);
                    if (run_inc == 4'(LOSS_CNT)) begin
                        state_nx    = SEARCH;
                        has_prev_nx = 1'b0;
                        run_nx      = 4'd0;
                    end else begin
                        run_nx = run_inc;
                    end
                end else begin
                    run_nx = 4'd0;
                end
            end
        end
        if (clear) begin
            wc_nx = '0;
            ec_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SEARCH;
            pred       <= 8'h00;
            has_prev   <= 1'b0;
            run        <= 4'd0;
            last_mode  <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_nx;
            pred       <= pred_nx;
            has_prev   <= has_prev_nx;
            run        <= run_nx;
            last_mode  <= last_mode_nx;
            err        <= err_nx;
            word_count <= wc_nx;
            err_count  <= ec_nx;
        end
    end

    assign locked = (state == LOCKED);

`ifdef STREAM_CHECKER_STICKY_EN
    // A fresh error wins over a simultaneous clear so the event is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_seen <= 1'b0;
        else
            err_seen <= err_nx | (err_seen & ~clear);
    end
`else
    assign err_seen = 1'b0;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Randomised and directed bench for stream_checker, compared against an integer-level reference model.
module tb_stream_checker;
    localparam int LOCK = 4;
    localparam int LOSS = 3;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;
`ifdef STREAM_CHECKER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          data_valid = 1'b0;
    logic          mode = 1'b0;
    logic          clear = 1'b0;
    logic          locked, err, err_seen;
    logic [CW-1:0] word_count, err_count;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit m_locked, m_has, m_last, m_err, m_es;
    int m_pred, m_run, m_wc, m_ec;

    stream_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .mode(mode), .clear(clear), .locked(locked), .err(err),
        .word_count(word_count), .err_count(err_count), .err_seen(err_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nxt(input int d, input bit lfsr);
        if (!lfsr) return (d + 1) % 256;
        return ((d * 2) % 256) ^ ((d >= 128) ? 9 : 0);
    endfunction

    function automatic int sat(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_has = 0; m_last = 0; m_err = 0; m_es = 0;
        m_pred = 0; m_run = 0; m_wc = 0; m_ec = 0;
    endtask

    task automatic model_word(input bit v, input int d, input bit md, input bit clr);
        bit e = 0;
        bit zero = md && (d == 0);
        if (v) begin
            if (m_has && (md != m_last)) begin
                m_locked = 0; m_run = 0;
                m_has = !zero;
                m_pred = nxt(d, md);
            end else if (!m_locked) begin
                if (zero) begin
                    m_has = 0; m_run = 0;
                end else begin
                    if (m_has) m_run = (d == m_pred) ? m_run + 1 : 0;
                    m_has = 1;
                    m_pred = nxt(d, md);
                    if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
                end
            end else begin
                e = (d != m_pred) || zero;
                m_pred = nxt(m_pred, md);
                m_wc = sat(m_wc);
                if (e) begin
                    m_ec = sat(m_ec);
                    m_run++;
                    if (m_run == LOSS) begin m_locked = 0; m_has = 0; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end
            m_last = md;
        end
        if (clr) begin m_wc = 0; m_ec = 0; m_es = 0; end
        m_err = e;
        if (STICKY && e) m_es = 1;
    endtask

    task automatic compare_all();
        check("locked", locked, m_locked);
        check("err", err, m_err);
        check("word_count", word_count, m_wc);
        check("err_count", err_count, m_ec);
        check("err_seen", err_seen, m_es);
    endtask

    // Inputs change 1ns after a rising edge; outputs are checked 1ns after the next one.
    task automatic step(input bit v, input int d, input bit md, input bit clr);
        data_valid = v; data_in = d[7:0]; mode = md; clear = clr;
        @(posedge clk);
        model_word(v, d, md, clr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0; data_valid = 1'b0; clear = 1'b0; mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        compare_all();
    endtask

    initial begin
        int g_val;
        bit g_mode;
        do_reset();

        // sequential acquire
        for (int i = 0; i < 16; i++) begin
            step(1, i, 0, 0);
            if (i == 3) check("pre_lock", locked, 0);
            if (i == 4) check("lock_rise", locked, 1);
        end
        check("seq_wc", word_count, 11);
        check("seq_ec", err_count, 0);

        // wrap 0xFF -> 0x00 while locked
        do_reset();
        for (int i = 0; i < 12; i++) step(1, (248 + i) % 256, 0, 0);
        check("wrap_lock", locked, 1);
        check("wrap_ec", err_count, 0);

        // LFSR sequence including 0x80 -> 0x09
        do_reset();
        g_val = 1;
        for (int i = 0; i < 10; i++) begin
            step(1, g_val, 1, 0);
            g_val = nxt(g_val, 1);
        end
        check("lfsr_lock", locked, 1);
        check("lfsr_ec", err_count, 0);

        // single corrupted word
        do_reset();
        for (int i = 16; i < 32; i++) step(1, i, 0, 0);
        step(1, 8'h55, 0, 0);
        check("single_err", err, 1);
        for (int i = 33; i < 38; i++) step(1, i, 0, 0);
        check("single_ec", err_count, 1);
        check("single_lock", locked, 1);
        check("single_sticky", err_seen, STICKY);

        // three corrupt words with idle gaps, then relock
        do_reset();
        for (int i = 16; i < 32; i++) step(1, i, 0, 0);
        step(1, 8'hAA, 0, 0);
        step(0, 8'h00, 0, 0);
        step(1, 8'hAB, 0, 0);
        step(0, 8'h33, 0, 0);
        step(1, 8'hAC, 0, 0);
        check("loss_ec", err_count, 3);
        check("loss_fall", locked, 0);
        for (int i = 48; i < 53; i++) step(1, i, 0, 0);
        check("relock", locked, 1);

        // mode toggle, then relock in LFSR
        do_reset();
        for (int i = 64; i < 72; i++) step(1, i, 0, 0);
        step(1, 1, 1, 0);
        check("toggle_fall", locked, 0);
        check("toggle_err", err, 0);
        g_val = 2;
        for (int i = 0; i < 6; i++) begin
            step(1, g_val, 1, 0);
            g_val = nxt(g_val, 1);
        end
        check("toggle_relock", locked, 1);

        // asynchronous reset while locked
        reset = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_err", err, 0);
        check("arst_wc", word_count, 0);
        check("arst_ec", err_count, 0);
        check("arst_es", err_seen, 0);
        do_reset();

        // clear together with an error, then saturation
        for (int i = 0; i < 10; i++) step(1, i, 0, 0);
        step(1, 8'hEE, 0, 1);
        check("clr_err", err, 1);
        check("clr_wc", word_count, 0);
        check("clr_ec", err_count, 0);
        for (int i = 11; i < 60; i++) step(1, i, 0, 0);
        check("sat_wc", word_count, CMAX);

        // randomised stream with corruption, gaps, mode flips and clears
        do_reset();
        g_mode = 0;
        g_val = 0;
        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(0, 99);
            int d;
            bit v = (r < 85);
            bit clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 2) begin
                g_mode = !g_mode;
                g_val = $urandom_range(1, 255);
            end
            d = g_val;
            if ($urandom_range(0, 99) < 4) d = (r < 10) ? 0 : $urandom_range(0, 255);
            step(v, d, g_mode, clr);
            if (v) g_val = nxt(g_val, g_mode);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_checker.md
# stream_checker

Self-synchronising pattern checker that consumes the 8-bit stream produced by the data generator stage. It tracks the sequential or LFSR pattern selected by `mode`, acquires lock after a run of correct words, and counts checked words and errors while locked. It sits directly downstream of the generator as the loop-back verifier for accelerator data paths.

## Interface
- `LOCK_CNT`, 4: consecutive matching words needed to enter LOCKED (1..15).
- `LOSS_CNT`, 3: consecutive mismatching words that drop LOCKED (1..15).
- `CNT_W`, 16: width of `word_count` and `err_count`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset: asserts immediately, releases synchronously to `clk`.
- `data_in`  in  8  word from generator.
- `data_valid`  in  1  `data_in` is a new word this cycle; tie high for a free-running generator.
- `mode`  in  1  0 = sequential, 1 = LFSR; sampled with each valid word.
- `clear`  in  1  synchronous clear of both counters and `err_seen`; state is unaffected.
- `locked`  out  1  checker is in LOCKED.
- `err`  out  1  one-cycle pulse per mismatching word checked in LOCKED.
- `word_count`  out  CNT_W  valid words checked while LOCKED; saturates at all-ones.
- `err_count`  out  CNT_W  mismatches counted while LOCKED; saturates at all-ones.
- `err_seen`  out  1  sticky error flag; see Configuration.

## Operation
Next-word rule, applied to a previous word `d`:
- Sequential: `d + 1` mod 256, so 0xFF is followed by 0x00.
- LFSR:
  - `n[0]=d[7]`, `n[1]=d[0]`, `n[2]=d[1]`, `n[3]=d[2]^d[7]`, `n[7:4]=d[6:3]`.
  - Example sequence: 0x01, 0x02, 0x04, …, 0x80, 0x09, 0x12.

State machine: SEARCH (reset state) and LOCKED. Internal registers:
- `pred` (8 bits) holds the predicted word.
- `has_prev` marks that `pred` is valid.
- `run` (4 bits) counts consecutive matches in SEARCH or consecutive misses in LOCKED.
- `last_mode` holds the mode seen with the previous valid word.

Per valid word:
- **Mode change** (`mode != last_mode` with `has_prev` set):
  - Go to SEARCH and set `run=0`.
  - Seed `pred` from the current word.
  - No `err` pulse.
- **SEARCH:**
  - If `has_prev` is clear: seed `pred = next(data_in)` and set `has_prev`.
  - Otherwise, a match increments `run`; a mismatch sets `run=0`.
  - In both cases `pred = next(data_in)`: the predictor always re-seeds from received data.
  - When `run` reaches `LOCK_CNT`, go to LOCKED and set `run=0`.
- **LOCKED:**
  - `pred = next(pred)`: the predictor free-runs, so a single corrupted word costs one error.
  - Each word increments `word_count`.
  - A mismatch pulses `err`, increments `err_count` and increments `run`.
  - A match sets `run=0`.
  - When `run` reaches `LOSS_CNT`, go to SEARCH and clear `has_prev`.
- **0x00 in LFSR mode:**
  - In LOCKED it is always a mismatch.
  - In SEARCH it clears `has_prev` and `run`; it is never used as a seed.
- **No valid word** (`data_valid` low): no state change, no counting.
- **`clear` in the same cycle as an error:** the counters end at 0 and `err` still pulses.

## Timing
- All outputs are registered. Reset values: `locked=0`, `err=0`, `word_count=0`, `err_count=0`, `err_seen=0`. Internal state resets to SEARCH with `has_prev=0`, `run=0`, `pred=0`, `last_mode=0`.
- `err` and the counter updates appear the cycle after the offending word is sampled.
- `locked` rises the cycle after the `LOCK_CNT`-th matching word is sampled.
- `locked` falls the cycle after the `LOSS_CNT`-th miss, or after a mode-change word.
- Reset asserted mid-operation forces every output to its reset value immediately, with no pending pulse.
- Saturated counters hold their value until `clear` or reset.

## Configuration
- `STREAM_CHECKER_STICKY_EN` defined:
  - `err_seen` sets on the first `err` pulse.
  - It holds until `clear` or reset.
  - `clear` in the same cycle as `err` leaves it set.
- Not defined: `err_seen` is tied to 0 and its logic is omitted.

## Test plan
- Reset, sequential mode, words 0x00..0x0F every cycle:
  - `locked` rises the cycle after 0x04.
  - `err_count=0` and `word_count=11` after 0x0F.
- Sequential stream crossing 0xFE, 0xFF, 0x00, 0x01 while locked: no `err`.
- LFSR mode with 0x01, 0x02, …, 0x80, 0x09, 0x12: lock acquired, `err_count=0`, and the 0x80→0x09 step is accepted.
- Locked sequential stream with 0x55 sent in place of 0x20:
  - One `err` pulse and `err_count=1`.
  - Stays locked; 0x21 is accepted.
  - `err_seen=1` with the macro defined, 0 without.
- Three consecutive corrupt words while locked:
  - `err_count=3` and `locked` falls the cycle after the third.
  - Relocks after 1 seed word plus 4 good words.
  - `data_valid` low gaps inside the run change nothing.
- `mode` toggles mid-stream:
  - `locked` falls with no `err` pulse, then relocks.
  - `reset` asserted while locked forces all outputs to 0 immediately.
  - `clear` together with an error leaves both counters at 0.
